// File: rtl/hdc_seq_pkg.sv
// Shared types and constants for the one-shot HDC dataset sequencer.
package hdc_seq_pkg;

  localparam int LABEL_W = 5;

  // Drain waits after the last slot: label N-2, label N-1, then the finished strobe.
  localparam int DRAIN_W0       = 2;
  localparam int DRAIN_W1       = 12;
  localparam int DRAIN_W2_TRAIN = 11;
  localparam int DRAIN_W2_TEST  = 12;

  typedef enum logic [3:0] {
    IDLE,
    TRAIN_FETCH,
    TRAIN_SLOT,
    TRAIN_DRAIN,
    BINARIZE,
    TEST_FETCH,
    TEST_SLOT,
    TEST_DRAIN,
    FINISH
  } hdc_seq_state_t;

endpackage

// File: rtl/hdc_label_delay.sv
// Two-stage label delay line. A push shifts the older stage out into tap_i2,
// so tap_i2 holds the label of sample i-2 once sample i has been pushed.
module hdc_label_delay #(
  parameter int LABEL_W = hdc_seq_pkg::LABEL_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               clear,
  input  logic [LABEL_W-1:0] label_in,
  output logic [LABEL_W-1:0] tap_i2,
  output logic [LABEL_W-1:0] tap_old,
  output logic [LABEL_W-1:0] tap_new
);

  // NOTE: the line is only a few flops, so it is reset like any other state;
  // a genuine RAM-based delay would be cleared with the clear input instead.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tap_i2  <= '0;
      tap_old <= '0;
      tap_new <= '0;
    end else if (clear) begin
      tap_i2  <= '0;
      tap_old <= '0;
      tap_new <= '0;
    end else if (push) begin
      tap_i2  <= tap_old;
      tap_old <= tap_new;
      tap_new <= label_in;
    end
  end

endmodule

// File: rtl/hdc_dataset_sequencer.sv
// Drives oneshot_hdc_top through train, binarize and test phases.
// Define HDC_SEQ_TALLY_EN to build the on-chip correct-inference tally.
module hdc_dataset_sequencer
  import hdc_seq_pkg::*;
#(
  parameter int TRAIN_COUNT = 6238,
  parameter int TEST_COUNT  = 1559,
  parameter int LABEL_W     = hdc_seq_pkg::LABEL_W,
  parameter int SLOT_CYCLES = 12,
  parameter int BIN_CYCLES  = 260,
  parameter int IDX_W       = 13,
  parameter int CNT_W       = 11
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               go,
  output logic               sample_req,
  output logic [IDX_W-1:0]   sample_idx,
  output logic               sample_test,
  input  logic               sample_ack,
  input  logic [LABEL_W-1:0] label_in,
  output logic               start_mapping,
  output logic [LABEL_W-1:0] class_select_bits,
  output logic               training_dataset_finished,
  output logic               testing_dataset_finished,
  input  logic [LABEL_W-1:0] class_inference,
  input  logic               checking_inference,
  output logic [CNT_W-1:0]   correct_count,
  output logic               busy,
  output logic               run_done
);

  localparam int DRAIN_SPAN = SLOT_CYCLES + DRAIN_W0 + DRAIN_W1 + DRAIN_W2_TEST;
  localparam int TMR_MAX    = (BIN_CYCLES > DRAIN_SPAN) ? BIN_CYCLES : DRAIN_SPAN;
  localparam int TMR_W      = $clog2(TMR_MAX + 1);

  // One timer serves slot spacing, the drain and binarization; drain marks are
  // measured from the last start_mapping pulse.
  localparam logic [TMR_W-1:0] SLOT_LAST   = TMR_W'(SLOT_CYCLES - 1);
  localparam logic [TMR_W-1:0] SLOT_LBL    = TMR_W'(SLOT_CYCLES - 2);
  localparam logic [TMR_W-1:0] DR_T0       = TMR_W'(SLOT_CYCLES + DRAIN_W0 - 1);
  localparam logic [TMR_W-1:0] DR_T1       = TMR_W'(SLOT_CYCLES + DRAIN_W0 + DRAIN_W1 - 1);
  localparam logic [TMR_W-1:0] DR_T2_TRAIN = TMR_W'(SLOT_CYCLES + DRAIN_W0 + DRAIN_W1 + DRAIN_W2_TRAIN - 1);
  localparam logic [TMR_W-1:0] DR_T2_TEST  = TMR_W'(DRAIN_SPAN - 1);
  localparam logic [TMR_W-1:0] BIN_LAST    = TMR_W'(BIN_CYCLES - 1);
  localparam logic [IDX_W-1:0] TRAIN_LAST  = IDX_W'(TRAIN_COUNT - 1);
  localparam logic [IDX_W-1:0] TEST_LAST   = IDX_W'(TEST_COUNT - 1);

  hdc_seq_state_t     state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [LABEL_W-1:0] cls_q, cls_d;
  logic               test_q, test_d, acked_q, acked_d, req_q, req_d, sm_q, sm_d;
  logic               trf_q, trf_d, tef_q, tef_d, busy_q, done_q, done_d;
  logic               push, clear, last;
  logic [LABEL_W-1:0] tap_i2, tap_old, tap_new;

  hdc_label_delay #(.LABEL_W(LABEL_W)) u_delay (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .clear    (clear),
    .label_in (label_in),
    .tap_i2   (tap_i2),
    .tap_old  (tap_old),
    .tap_new  (tap_new)
  );

  // NOTE: every signal gets a default before the case so no path infers a latch.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    idx_d   = idx_q;
    test_d  = test_q;
    acked_d = acked_q;
    cls_d   = cls_q;
    req_d   = 1'b0;
    sm_d    = 1'b0;
    trf_d   = 1'b0;
    tef_d   = 1'b0;
    done_d  = 1'b0;
    push    = 1'b0;
    clear   = 1'b0;
    last    = test_q ? (idx_q == TEST_LAST) : (idx_q == TRAIN_LAST);
    case (state_q)
      IDLE: begin
        if (go) begin
          state_d = TRAIN_FETCH;
          req_d   = 1'b1;
          idx_d   = '0;
          test_d  = 1'b0;
          acked_d = 1'b0;
          tmr_d   = SLOT_LAST;
        end
      end
      TRAIN_FETCH, TEST_FETCH: begin
        if (tmr_q != SLOT_LAST) tmr_d = tmr_q + 1'b1;
        if (sample_ack && !acked_q) begin
          push    = 1'b1;
          acked_d = 1'b1;
        end
        if ((sample_ack || acked_q) && tmr_q == SLOT_LAST) begin
          state_d = test_q ? TEST_SLOT : TRAIN_SLOT;
          sm_d    = 1'b1;
          tmr_d   = '0;
        end
      end
      TRAIN_SLOT, TEST_SLOT: begin
        tmr_d = tmr_q + 1'b1;
        if (tmr_q == SLOT_LBL) begin
          if (idx_q >= IDX_W'(2)) cls_d = tap_i2;
          if (last) begin
            state_d = test_q ? TEST_DRAIN : TRAIN_DRAIN;
          end else begin
            state_d = test_q ? TEST_FETCH : TRAIN_FETCH;
            req_d   = 1'b1;
            idx_d   = idx_q + 1'b1;
            acked_d = 1'b0;
          end
        end
      end
      TRAIN_DRAIN, TEST_DRAIN: begin
        tmr_d = tmr_q + 1'b1;
        if (tmr_q == DR_T0) cls_d = tap_old;
        if (tmr_q == DR_T1) cls_d = tap_new;
        if (tmr_q == (test_q ? DR_T2_TEST : DR_T2_TRAIN)) begin
          tmr_d = '0;
          if (test_q) begin
            tef_d   = 1'b1;
            state_d = FINISH;
          end else begin
            trf_d   = 1'b1;
            state_d = BINARIZE;
          end
        end
      end
      BINARIZE: begin
        tmr_d = tmr_q + 1'b1;
        if (tmr_q == BIN_LAST) begin
          clear   = 1'b1;
          state_d = TEST_FETCH;
          req_d   = 1'b1;
          idx_d   = '0;
          test_d  = 1'b1;
          acked_d = 1'b0;
          tmr_d   = SLOT_LAST;
        end
      end
      FINISH: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      idx_q   <= '0;
      test_q  <= 1'b0;
      acked_q <= 1'b0;
      cls_q   <= '0;
      req_q   <= 1'b0;
      sm_q    <= 1'b0;
      trf_q   <= 1'b0;
      tef_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      idx_q   <= idx_d;
      test_q  <= test_d;
      acked_q <= acked_d;
      cls_q   <= cls_d;
      req_q   <= req_d;
      sm_q    <= sm_d;
      trf_q   <= trf_d;
      tef_q   <= tef_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= done_d;
    end
  end

`ifdef HDC_SEQ_TALLY_EN
  logic [CNT_W-1:0] cnt_q;
  logic             tally_state;

  always_comb tally_state = state_q inside {TEST_FETCH, TEST_SLOT, TEST_DRAIN, FINISH};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (state_q == IDLE && go) begin
      cnt_q <= '0;
    end else if (tally_state && checking_inference &&
                 class_inference == cls_q && cnt_q != '1) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign correct_count = cnt_q;
`else
  logic unused_tally;
  assign unused_tally  = ^{class_inference, checking_inference};
  assign correct_count = '0;
`endif

  assign sample_req                = req_q;
  assign sample_idx                = idx_q;
  assign sample_test               = test_q;
  assign start_mapping             = sm_q;
  assign class_select_bits         = cls_q;
  assign training_dataset_finished = trf_q;
  assign testing_dataset_finished  = tef_q;
  assign busy                      = busy_q;
  assign run_done                  = done_q;

endmodule

// File: tb/tb_hdc_dataset_sequencer.sv
// Directed bench for hdc_dataset_sequencer with 4 train / 4 test samples.
// Expected tally depends on whether HDC_SEQ_TALLY_EN is defined.
module tb_hdc_dataset_sequencer;

  localparam int LW = 5, IW = 13, CW = 11;
`ifdef HDC_SEQ_TALLY_EN
  localparam int EXP_CNT = 3;
`else
  localparam int EXP_CNT = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          go = 1'b0;
  logic          sample_req, sample_test, start_mapping, busy, run_done;
  logic          training_dataset_finished, testing_dataset_finished;
  logic [IW-1:0] sample_idx;
  logic [LW-1:0] class_select_bits;
  logic [CW-1:0] correct_count;
  logic          sample_ack = 1'b0;
  logic [LW-1:0] label_in = '0;
  logic [LW-1:0] class_inference = '0;
  logic          checking_inference = 1'b0;

  hdc_dataset_sequencer #(
    .TRAIN_COUNT(4), .TEST_COUNT(4), .LABEL_W(LW), .SLOT_CYCLES(12),
    .BIN_CYCLES(260), .IDX_W(IW), .CNT_W(CW)
  ) dut (
    .clk                       (clk),
    .rst                       (rst),
    .go                        (go),
    .sample_req                (sample_req),
    .sample_idx                (sample_idx),
    .sample_test               (sample_test),
    .sample_ack                (sample_ack),
    .label_in                  (label_in),
    .start_mapping             (start_mapping),
    .class_select_bits         (class_select_bits),
    .training_dataset_finished (training_dataset_finished),
    .testing_dataset_finished  (testing_dataset_finished),
    .class_inference           (class_inference),
    .checking_inference        (checking_inference),
    .correct_count             (correct_count),
    .busy                      (busy),
    .run_done                  (run_done)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [LW-1:0] train_lbl [4] = '{5'd3, 5'd7, 5'd1, 5'd9};
  logic [LW-1:0] test_lbl  [4] = '{5'd2, 5'd5, 5'd8, 5'd11};

  int n_tests = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Loader: acks in the request cycle, except train sample 2 in delay mode,
  // whose ack lands 20 cycles after sample 1's pulse.
  logic          delay_mode = 1'b0;
  int            stray_req_cnt = 0, stray_done_cnt = 0;
  logic          pend = 1'b0, ptest = 1'b0;
  logic [IW-1:0] pidx = '0;
  int            wait_left = 0;
  always @(negedge clk) begin
    sample_ack = 1'b0;
    if (sample_req) begin
      pend      = 1'b1;
      pidx      = sample_idx;
      ptest     = sample_test;
      wait_left = (delay_mode && !sample_test && sample_idx == 2) ? 9 : 0;
    end
    if (pend) begin
      if (wait_left == 0) begin
        sample_ack = 1'b1;
        label_in   = ptest ? test_lbl[pidx[1:0]] : train_lbl[pidx[1:0]];
        pend       = 1'b0;
      end else begin
        wait_left--;
      end
    end else if (stray_done_cnt != stray_req_cnt) begin
      sample_ack = 1'b1;
      label_in   = 5'd31;
      stray_done_cnt++;
    end
  end

  // Core model: strobes a check on each new test-phase label, answering
  // correctly except on the second one.
  int            core_k = 0;
  logic [LW-1:0] core_prev = '0;
  logic          core_busy_prev = 1'b0;
  always @(negedge clk) begin
    checking_inference = 1'b0;
    if (busy && !core_busy_prev) core_k = 0;
    if (busy && sample_test && class_select_bits != core_prev && core_k < 4) begin
      checking_inference = 1'b1;
      class_inference    = (core_k == 1) ? test_lbl[core_k] + 5'd1 : test_lbl[core_k];
      core_k++;
    end
    core_prev      = class_select_bits;
    core_busy_prev = busy;
  end

  // Event recorder, cleared at the start of each run.
  int            tp[$], xp[$], ct[$];
  logic [LW-1:0] cv[$];
  int            tr_fin = 0, te_fin = 0, done_cyc = 0, test_req = 0, n_fin = 0;
  logic [LW-1:0] cls_prev = '0;
  logic          busy_prev = 1'b0;
  always @(negedge clk) begin
    if (busy && !busy_prev) begin
      tp.delete(); xp.delete(); ct.delete(); cv.delete();
      tr_fin = 0; te_fin = 0; done_cyc = 0; test_req = 0;
    end
    if (start_mapping) begin
      if (sample_test) xp.push_back(int'(cyc));
      else             tp.push_back(int'(cyc));
    end
    if (class_select_bits != cls_prev) begin
      ct.push_back(int'(cyc));
      cv.push_back(class_select_bits);
    end
    if (training_dataset_finished) begin tr_fin = int'(cyc); n_fin++; end
    if (testing_dataset_finished)  begin te_fin = int'(cyc); n_fin++; end
    if (run_done) done_cyc = int'(cyc);
    if (sample_req && sample_test && test_req == 0) test_req = int'(cyc);
    cls_prev  = class_select_bits;
    busy_prev = busy;
  end

  task automatic pulse_go();
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic run_one(input bit dly);
    bit            ok;
    int            n_sm, exp_gap;
    int            exp_t [8];
    logic [LW-1:0] exp_v [8];
    delay_mode = dly;
    pulse_go();
    check("go_req", sample_req, 1);
    check("go_idx", sample_idx, 0);
    check("go_phase", sample_test, 0);
    check("go_busy", busy, 1);
    if (dly) begin
      n_sm = 0;
      for (int i = 0; i < 200 && n_sm < 2; i++) begin
        @(negedge clk);
        if (start_mapping) n_sm++;
      end
      check("second_pulse_seen", n_sm, 2);
      repeat (3) @(negedge clk);
      stray_req_cnt++;
      pulse_go();
      @(negedge clk);
      check("busy_go_idx", sample_idx, 1);
      check("busy_go_req", sample_req, 0);
    end
    ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      if (run_done) ok = 1'b1;
    end
    check("run_done_seen", ok, 1);
    @(negedge clk);
    check("train_pulses", tp.size(), 4);
    check("test_pulses", xp.size(), 4);
    check("label_changes", ct.size(), 8);
    if (tp.size() == 4 && xp.size() == 4) begin
      for (int i = 1; i < 4; i++) begin
        exp_gap = (dly && i == 2) ? 21 : 12;
        check($sformatf("train_gap%0d", i), tp[i] - tp[i-1], exp_gap);
        check($sformatf("test_gap%0d", i), xp[i] - xp[i-1], 12);
      end
      check("train_fin_delay", tr_fin - tp[3], 37);
      check("bin_to_test_req", test_req - tr_fin, 260);
      check("test_fin_delay", te_fin - xp[3], 38);
      check("run_done_delay", done_cyc - te_fin, 1);
      if (ct.size() == 8) begin
        exp_t = '{tp[2] + 11, tp[3] + 11, tp[3] + 14, tp[3] + 26,
                  xp[2] + 11, xp[3] + 11, xp[3] + 14, xp[3] + 26};
        exp_v = '{train_lbl[0], train_lbl[1], train_lbl[2], train_lbl[3],
                  test_lbl[0], test_lbl[1], test_lbl[2], test_lbl[3]};
        for (int k = 0; k < 8; k++) begin
          check($sformatf("label%0d_value", k), cv[k], exp_v[k]);
          check($sformatf("label%0d_time", k), ct[k], exp_t[k]);
        end
      end
    end
    repeat (5) @(negedge clk);
    check("correct_count", correct_count, EXP_CNT);
    check("idle_busy", busy, 0);
  endtask

  initial begin
    bit ok;
    int fin_before;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_req", sample_req, 0);
    check("rst_idx", sample_idx, 0);
    check("rst_phase", sample_test, 0);
    check("rst_mapping", start_mapping, 0);
    check("rst_class", class_select_bits, 0);
    check("rst_count", correct_count, 0);
    check("rst_strobes", {training_dataset_finished, testing_dataset_finished, run_done}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_one(1'b0);
    run_one(1'b1);

    // Abort during binarization, then restart from scratch.
    pulse_go();
    ok = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk);
      if (training_dataset_finished) ok = 1'b1;
    end
    check("abort_train_fin_seen", ok, 1);
    repeat (20) @(negedge clk);
    check("pre_abort_idx", sample_idx, 3);
    fin_before = n_fin;
    #2 rst = 1'b1;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_req", sample_req, 0);
    check("abort_idx", sample_idx, 0);
    check("abort_phase", sample_test, 0);
    check("abort_class", class_select_bits, 0);
    check("abort_count", correct_count, 0);
    rst = 1'b0;
    repeat (300) @(negedge clk);
    check("abort_no_strobes", n_fin, fin_before);
    check("abort_stays_idle", busy, 0);
    pulse_go();
    check("restart_req", sample_req, 1);
    check("restart_idx", sample_idx, 0);
    check("restart_phase", sample_test, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
